mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multicycle sequencing FSM that sits directly upstream of the ALU.
- Decodes the fetched instruction word and drives the ALU `func`/`typ` selects.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and generates PC, IR, register-file and memory strobes.
- Accounts for the ALU's registered result: the result is valid one cycle after EXEC.

Parameters:
- MEM_TIMEOUT, 200: maximum cycles waiting on mem_ready in FETCH or MEM before halting; 0 disables the timeout.
- TIMEOUT_W, 8: width of the wait counter; MEM_TIMEOUT must be < 2**TIMEOUT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from the memory read port / IR.
- mem_ready  in  1  memory handshake; access completes in the cycle it is high.
- eq  in  1  rs1 == rs2 compare from the register read path.
- alu_func  out  5  ALU func select, registered.
- alu_typ  out  2  ALU type select (00 R, 01 S, 10 I-imm14), registered.
- pc_write  out  1  PC load strobe.
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target.
- ir_write  out  1  IR load strobe.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register-file write strobe.
- wb_src  out  1  0 ALU_result, 1 memory data.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- illegal  out  1  sticky; set on an undecodable instruction.
- timeout  out  1  sticky; set on memory wait overflow.

Behaviour:
- Instruction fields:
  - func = instr[31:27]
  - typ = instr[2:1]
- Decode classes:
  - ALU op: func 00000 with typ 00/01/10; func 00001 with typ 00/10; func 00010 with typ 00/01.
  - LW: func 00011, typ 10.
  - SW: func 00100, typ 10.
  - BEQ: func 00101, typ 10.
  - J: func 00110, typ 11.
  - Everything else is illegal.
- Reset (synchronous): state=FETCH; alu_func=0, alu_typ=0, illegal=0, timeout=0, wait counter=0. All strobes are low during the reset cycle.
- Strobes are Moore/Mealy combinational from state, registered class and eq/mem_ready. Only one strobe group is active per state.
- FETCH:
  - mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Register the class; load alu_func/alu_typ. LW/SW force alu_func=00001, alu_typ=10 (address = rs1+imm). BEQ forces 00010/00.
  - Illegal instruction: go to HALT and set illegal.
  - J: pc_write=1, pc_src=10, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - ALU samples its selects on this cycle's rising edge.
  - BEQ: pc_write=eq, pc_src=01, go to FETCH.
  - ALU op: go to WB.
  - LW/SW: go to MEM.
- MEM:
  - LW drives mem_read=1; SW drives mem_write=1.
  - Hold until mem_ready=1. Then LW goes to WB; SW goes to FETCH.
- WB:
  - reg_write=1; wb_src=1 for LW, 0 for ALU ops; go to FETCH.
- HALT: all strobes 0; stays in HALT until reset.
- Wait counter:
  - Cleared on every state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while still waiting, go to HALT and set timeout. No strobe fires that cycle.
- Simultaneous events:
  - reset overrides everything, including mem_ready in the same cycle.
  - mem_ready arriving on the timeout cycle wins (access completes, no timeout).
- Latency: ALU op 4 cycles, LW 5, SW 4, BEQ 3, J 2. Add memory wait cycles to each.

Optional Feature:
- Macro: MC_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs retired_cnt (32 bits) and stall_cnt (32 bits), reset to 0.
  - retired_cnt increments on entry to FETCH from WB, EXEC (BEQ), DECODE (J) or MEM (SW).
  - stall_cnt increments every cycle spent waiting on mem_ready.
  - Both wrap at 2**32.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state encoding enum;
  - func codes: FUNC_AND=00000, FUNC_ADD=00001, FUNC_SUB=00010, FUNC_LW, FUNC_SW, FUNC_BEQ, FUNC_J;
  - typ codes (TYP_R, TYP_S, TYP_I14, TYP_J);
  - instruction-class enum;
  - pc_src codes.
- Sub-module mc_decoder is natural: purely combinational, maps func/typ to class, ALU selects and illegal flag. The FSM instantiates it.

Test Plan:
- ADD, instr func=00001 typ=00, mem_ready tied 1:
  - states 0,1,2,4,0;
  - alu_func=00001, alu_typ=00 from cycle 2;
  - single reg_write pulse with wb_src=0.
- LW func=00011 typ=10, mem_ready low 3 cycles in MEM:
  - MEM held 4 cycles with mem_read=1 throughout;
  - alu_typ=10;
  - WB with wb_src=1.
- BEQ with eq=1:
  - pc_write=1 and pc_src=01 in EXEC, next state FETCH;
  - no reg_write.
- BEQ with eq=0: pc_write=0 in EXEC.
- func=11111 → HALT, illegal=1; both persist with mem_ready toggling until reset; then state=0, illegal=0.
- reset asserted during MEM of SW → next cycle state=FETCH; mem_write, pc_write and reg_write all 0 that cycle.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT after 4 wait cycles, timeout=1, ir_write never pulses.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle control unit
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [4:0] FUNC_AND = 5'b00000;
  localparam logic [4:0] FUNC_ADD = 5'b00001;
  localparam logic [4:0] FUNC_SUB = 5'b00010;
  localparam logic [4:0] FUNC_LW  = 5'b00011;
  localparam logic [4:0] FUNC_SW  = 5'b00100;
  localparam logic [4:0] FUNC_BEQ = 5'b00101;
  localparam logic [4:0] FUNC_J   = 5'b00110;

  localparam logic [1:0] TYP_R   = 2'b00;
  localparam logic [1:0] TYP_S   = 2'b01;
  localparam logic [1:0] TYP_I14 = 2'b10;
  localparam logic [1:0] TYP_J   = 2'b11;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_J   = 3'd4,
    CLS_ILL = 3'd5
  } cls_e;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic [4:0] instr_func(input logic [31:0] ins);
    return ins[31:27];
  endfunction

  function automatic logic [1:0] instr_typ(input logic [31:0] ins);
    return ins[2:1];
  endfunction

endpackage

// File: rtl/mc_decoder.sv
// rtl/mc_decoder.sv - combinational func/typ decode into class and ALU selects
module mc_decoder
  import mc_pkg::*;
(
  input  logic [4:0] func,
  input  logic [1:0] typ,
  output cls_e       cls,
  output logic [4:0] alu_func,
  output logic [1:0] alu_typ,
  output logic       illegal
);

  always_comb begin
    cls      = CLS_ILL;
    alu_func = func;
    alu_typ  = typ;
    case (func)
      FUNC_AND: if (typ != TYP_J) cls = CLS_ALU;
      FUNC_ADD: if (typ == TYP_R || typ == TYP_I14) cls = CLS_ALU;
      FUNC_SUB: if (typ == TYP_R || typ == TYP_S) cls = CLS_ALU;
      // Memory ops compute rs1+imm; BEQ compares by subtraction.
      FUNC_LW: begin
        if (typ == TYP_I14) cls = CLS_LW;
        alu_func = FUNC_ADD;
        alu_typ  = TYP_I14;
      end
      FUNC_SW: begin
        if (typ == TYP_I14) cls = CLS_SW;
        alu_func = FUNC_ADD;
        alu_typ  = TYP_I14;
      end
      FUNC_BEQ: begin
        if (typ == TYP_I14) cls = CLS_BEQ;
        alu_func = FUNC_SUB;
        alu_typ  = TYP_R;
      end
      FUNC_J: if (typ == TYP_J) cls = CLS_J;
      default: cls = CLS_ILL;
    endcase
    illegal = (cls == CLS_ILL);
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer ahead of the ALU
// Optional retired/stall counters are built when MC_PERF_COUNTERS_EN is defined.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        eq,
  output logic [4:0]  alu_func,
  output logic [1:0]  alu_typ,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        wb_src,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d;
  logic [4:0]           alu_func_q, alu_func_d;
  logic [1:0]           alu_typ_q, alu_typ_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic                 waiting;
  logic                 wait_hit;

  cls_e       dec_cls;
  logic [4:0] dec_alu_func;
  logic [1:0] dec_alu_typ;
  logic       dec_illegal;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^{instr[26:3], instr[0]};

  mc_decoder u_decoder (
    .func     (instr_func(instr)),
    .typ      (instr_typ(instr)),
    .cls      (dec_cls),
    .alu_func (dec_alu_func),
    .alu_typ  (dec_alu_typ),
    .illegal  (dec_illegal)
  );

  // The counter stops advancing at MEM_TIMEOUT, so it never needs to wrap.
  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_func_d = alu_func_q;
    alu_typ_d  = alu_typ_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    waiting    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_src     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          mem_read = 1'b1;
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
          state_d  = ST_DECODE;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          mem_read = 1'b1;
          waiting  = 1'b1;
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          alu_func_d = dec_alu_func;
          alu_typ_d  = dec_alu_typ;
          if (dec_cls == CLS_J) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BEQ: begin
            pc_write = eq;
            pc_src   = PC_BRANCH;
            state_d  = ST_FETCH;
          end
          CLS_ALU:         state_d = ST_WB;
          CLS_LW, CLS_SW:  state_d = ST_MEM;
          default:         state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          mem_read  = (cls_q == CLS_LW);
          mem_write = (cls_q == CLS_SW);
          state_d   = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          mem_read  = (cls_q == CLS_LW);
          mem_write = (cls_q == CLS_SW);
          waiting   = 1'b1;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_src    = (cls_q == CLS_LW);
        state_d   = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase

    // Reset must silence every strobe even if mem_ready lands in the same cycle.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      wb_src    = 1'b0;
      pc_src    = PC_INC;
      waiting   = 1'b0;
    end

    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && wait_q != '1) begin
      wait_d = wait_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      cls_q      <= CLS_ALU;
      alu_func_q <= '0;
      alu_typ_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      alu_func_q <= alu_func_d;
      alu_typ_q  <= alu_typ_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      wait_q     <= wait_d;
    end
  end

`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        retire_evt;

  assign retire_evt = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_HALT);

  always_comb begin
    retired_cnt_d = retired_cnt_q + (retire_evt ? 32'd1 : 32'd0);
    stall_cnt_d   = stall_cnt_q + (waiting ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

  assign state    = state_q;
  assign alu_func = alu_func_q;
  assign alu_typ  = alu_typ_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit
module tb_mc_control_unit;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        eq = 1'b0;
  logic [4:0]  alu_func;
  logic [1:0]  alu_typ;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, wb_src;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        illegal, timeout;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  mc_control_unit #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .mem_ready (mem_ready),
    .eq        (eq),
    .alu_func  (alu_func),
    .alu_typ   (alu_typ),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .wb_src    (wb_src),
    .state     (state),
    .illegal   (illegal),
    .timeout   (timeout)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        eqv;
    logic [31:0] ins;
  } stim_t;

  stim_t       stim_q[$];
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] mk_instr(input logic [4:0] f, input logic [1:0] t);
    return {f, 24'h0, t, 1'b0};
  endfunction

  // {state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, wb_src}
  function automatic logic [10:0] mk(input int st, input bit pcw, input int pcs, input bit irw,
                                     input bit mr, input bit mw, input bit rw, input bit wb);
    return {3'(st), pcw, 2'(pcs), irw, mr, mw, rw, wb};
  endfunction

  function automatic logic [10:0] obs();
    return {state, pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, wb_src};
  endfunction

  logic [10:0] e_fetch, e_fwait, e_dec, e_exec, e_halt;
  logic [31:0] i_add, i_lw, i_sw, i_beq, i_j, i_bad, i_add_s;

  task automatic push(input bit r, input bit rdy, input bit e, input logic [31:0] ins,
                      input logic [10:0] x);
    stim_q.push_back('{rst: r, rdy: rdy, eqv: e, ins: ins});
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    instr = i_add;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL reset_strobes got %h want %h", obs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    else passes++;
    checks++;
    if ({alu_func, alu_typ, illegal, timeout} !== 9'h0)
      $display("FAIL reset_regs got %h want 000", {alu_func, alu_typ, illegal, timeout});
    else passes++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_alu_add();
    stim_t s;
    logic [10:0] e;
    do_reset();
    push(0, 1, 0, i_add, e_fetch);
    push(0, 1, 0, i_add, e_dec);
    push(0, 1, 0, i_add, e_exec);
    push(0, 1, 0, i_add, mk(4, 0, 0, 0, 0, 0, 1, 0));
    push(0, 1, 0, i_add, e_fetch);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL add cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      if (i == 2) begin
        checks++;
        if ({alu_func, alu_typ} !== {FUNC_ADD, TYP_R})
          $display("FAIL add_sel got %h want %h", {alu_func, alu_typ}, {FUNC_ADD, TYP_R});
        else passes++;
      end
    end
  endtask

  task automatic test_lw_wait();
    stim_t s;
    logic [10:0] e;
    do_reset();
    push(0, 1, 0, i_lw, e_fetch);
    push(0, 1, 0, i_lw, e_dec);
    push(0, 1, 0, i_lw, e_exec);
    for (int k = 0; k < 3; k++) push(0, 0, 0, i_lw, mk(3, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, i_lw, mk(3, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, i_lw, mk(4, 0, 0, 0, 0, 0, 1, 1));
    push(0, 1, 0, i_lw, e_fetch);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL lw cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      if (i == 2) begin
        checks++;
        if ({alu_func, alu_typ} !== {FUNC_ADD, TYP_I14})
          $display("FAIL lw_sel got %h want %h", {alu_func, alu_typ}, {FUNC_ADD, TYP_I14});
        else passes++;
      end
    end
  endtask

  task automatic test_beq();
    stim_t s;
    logic [10:0] e;
    do_reset();
    push(0, 1, 1, i_beq, e_fetch);
    push(0, 1, 1, i_beq, e_dec);
    push(0, 1, 1, i_beq, mk(2, 1, 1, 0, 0, 0, 0, 0));
    push(0, 1, 0, i_beq, e_fetch);
    push(0, 1, 0, i_beq, e_dec);
    push(0, 1, 0, i_beq, mk(2, 0, 1, 0, 0, 0, 0, 0));
    push(0, 1, 0, i_beq, e_fetch);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL beq cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      if (i == 2) begin
        checks++;
        if ({alu_func, alu_typ} !== {FUNC_SUB, TYP_R})
          $display("FAIL beq_sel got %h want %h", {alu_func, alu_typ}, {FUNC_SUB, TYP_R});
        else passes++;
      end
    end
  endtask

  task automatic test_illegal();
    stim_t s;
    logic [10:0] e;
    do_reset();
    push(0, 1, 0, i_bad, e_fetch);
    push(0, 1, 0, i_bad, e_dec);
    for (int k = 0; k < 5; k++) push(0, k[0], 0, i_bad, e_halt);
    push(1, 1, 0, i_bad, e_halt);
    push(0, 0, 0, i_add_s, e_fwait);
    push(0, 1, 0, i_add_s, e_fetch);
    push(0, 1, 0, i_add_s, e_dec);
    push(0, 1, 0, i_add_s, e_halt);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL illegal cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      checks++;
      if (illegal !== ((i >= 2 && i <= 7) || i == 11))
        $display("FAIL illegal_flag cyc%0d got %b want %b", i, illegal, (i >= 2 && i <= 7) || i == 11);
      else passes++;
    end
  endtask

  task automatic test_sw_reset();
    stim_t s;
    logic [10:0] e;
    do_reset();
    push(0, 1, 0, i_sw, e_fetch);
    push(0, 1, 0, i_sw, e_dec);
    push(0, 1, 0, i_sw, e_exec);
    push(0, 0, 0, i_sw, mk(3, 0, 0, 0, 0, 1, 0, 0));
    push(1, 1, 0, i_sw, mk(3, 0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 0, i_sw, e_fwait);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL sw_reset cyc%0d got %h want %h", i, obs(), e);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [10:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 0, 0, i_add, e_fwait);
    push(0, 0, 0, i_add, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, i_add, e_halt);
    push(0, 1, 0, i_add, e_halt);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL timeout cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      checks++;
      if (timeout !== (i >= 5)) $display("FAIL timeout_flag cyc%0d got %b want %b", i, timeout, i >= 5);
      else passes++;
    end
    // mem_ready on the timeout cycle completes the fetch instead of halting
    do_reset();
    for (int k = 0; k < 4; k++) push(0, 0, 0, i_add, e_fwait);
    push(0, 1, 0, i_add, e_fetch);
    push(0, 1, 0, i_add, e_dec);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL timeout_race cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      checks++;
      if (timeout !== 1'b0) $display("FAIL timeout_race_flag cyc%0d got %b want 0", i, timeout);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic [10:0] e;
    do_reset();
    push(0, 1, 0, i_add, e_fetch);
    push(0, 1, 0, i_add, e_dec);
    push(0, 1, 0, i_add, e_exec);
    push(0, 1, 0, i_add, mk(4, 0, 0, 0, 0, 0, 1, 0));
    push(0, 1, 0, i_sw, e_fetch);
    push(0, 1, 0, i_sw, e_dec);
    push(0, 1, 0, i_sw, e_exec);
    push(0, 0, 0, i_sw, mk(3, 0, 0, 0, 0, 1, 0, 0));
    push(0, 1, 0, i_sw, mk(3, 0, 0, 0, 0, 1, 0, 0));
    push(0, 1, 0, i_j, e_fetch);
    push(0, 1, 0, i_j, mk(1, 1, 2, 0, 0, 0, 0, 0));
    push(0, 1, 0, i_add, e_fetch);
    for (int i = 0; stim_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; mem_ready = s.rdy; eq = s.eqv; instr = s.ins;
      #1;
      checks++;
      if (obs() !== e) $display("FAIL b2b cyc%0d got %h want %h", i, obs(), e);
      else passes++;
      if (i == 6) begin
        checks++;
        if ({alu_func, alu_typ} !== {FUNC_ADD, TYP_I14})
          $display("FAIL sw_sel got %h want %h", {alu_func, alu_typ}, {FUNC_ADD, TYP_I14});
        else passes++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    e_fetch = mk(0, 1, 0, 1, 1, 0, 0, 0);
    e_fwait = mk(0, 0, 0, 0, 1, 0, 0, 0);
    e_dec   = mk(1, 0, 0, 0, 0, 0, 0, 0);
    e_exec  = mk(2, 0, 0, 0, 0, 0, 0, 0);
    e_halt  = mk(5, 0, 0, 0, 0, 0, 0, 0);
    i_add   = mk_instr(5'b00001, 2'b00);
    i_lw    = mk_instr(5'b00011, 2'b10);
    i_sw    = mk_instr(5'b00100, 2'b10);
    i_beq   = mk_instr(5'b00101, 2'b10);
    i_j     = mk_instr(5'b00110, 2'b11);
    i_bad   = mk_instr(5'b11111, 2'b00);
    i_add_s = mk_instr(5'b00001, 2'b01);

    test_reset();
    test_alu_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_sw_reset();
    test_timeout();
    test_back_to_back();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
